// File: rtl/ex_result_flags.sv
`default_nettype none
// ============================================================================
// Module      : ex_result_flags
// Description : Execute-stage back end. Registers the ALU result, the
//               destination index and the write-enable into the EX/MEM
//               pipeline register. Maintains the Z/N/V condition flags,
//               which change only when an instruction commits from EX.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_result_flags #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] res,
    input  logic [RW-1:0] dst,
    input  logic          wr_en,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [DW-1:0] out_res,
    output logic [RW-1:0] out_dst,
    output logic          out_wr_en,
    output logic          zr,
    output logic          neg,
    output logic          ov
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD    = 4'b0000;
    localparam logic [3:0] c_OP_PADDSB = 4'b0001;
    localparam logic [3:0] c_OP_SUB    = 4'b0010;
    localparam logic [3:0] c_OP_AND    = 4'b0011;
    localparam logic [3:0] c_OP_NOR    = 4'b0100;
    localparam logic [3:0] c_OP_SLL    = 4'b0101;
    localparam logic [3:0] c_OP_SRL    = 4'b0110;
    localparam logic [3:0] c_OP_SRA    = 4'b0111;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic          r_valid;
    logic [DW-1:0] r_res;
    logic [RW-1:0] r_dst;
    logic          r_wr_en;
    logic          r_zr;
    logic          r_neg;
    logic          r_ov;

    // ------------------------------------------------------------------
    // Combinational flag candidates
    // ------------------------------------------------------------------
    logic w_commit;
    logic w_upd_znv;     // ADD/SUB: all three flags
    logic w_upd_z;       // logic, shift and packed-add ops: zero flag only
    logic w_is_sub;
    logic w_res_zero;
    logic w_sign_a;
    logic w_sign_b;
    logic w_sign_r;
    logic w_ov_add;
    logic w_ov_sub;
    logic w_ov_new;

    // Only the sign bits of the operands feed the overflow logic; the
    // remaining bits are reduced here so they are visibly accounted for.
    logic w_unused_operand_bits;
    assign w_unused_operand_bits = ^{in1[DW-2:0], in2[DW-2:0]};

    // An instruction commits only when it is real and neither held nor squashed.
    assign w_commit   = in_valid & ~stall & ~flush;

    assign w_res_zero = (res == '0);
    assign w_sign_a   = in1[DW-1];
    assign w_sign_b   = in2[DW-1];
    assign w_sign_r   = res[DW-1];

    // ADD overflows when both operands share a sign the result does not.
    assign w_ov_add   = (w_sign_a == w_sign_b) & (w_sign_r != w_sign_a);
    // SUB (in1 - in2) overflows when operand signs differ and the result
    // sign departs from the minuend.
    assign w_ov_sub   = (w_sign_a != w_sign_b) & (w_sign_r != w_sign_a);
    assign w_ov_new   = w_is_sub ? w_ov_sub : w_ov_add;

    // Classify the opcode into its flag-update group.
    always_comb begin
        w_upd_znv = 1'b0;
        w_upd_z   = 1'b0;
        w_is_sub  = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_upd_znv = 1'b1;
            end
            c_OP_SUB: begin
                w_upd_znv = 1'b1;
                w_is_sub  = 1'b1;
            end
            // PADDSB saturates per byte upstream, so it never reports
            // overflow; zero is judged on the whole packed word.
            c_OP_PADDSB,
            c_OP_AND,
            c_OP_NOR,
            c_OP_SLL,
            c_OP_SRL,
            c_OP_SRA: begin
                w_upd_z = 1'b1;
            end
            default: begin
                w_upd_znv = 1'b0;
                w_upd_z   = 1'b0;
            end
        endcase
    end

    // EX/MEM pipeline register: flush inserts a bubble, stall holds, else load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_dst   <= '0;
            r_wr_en <= 1'b0;
        end else if (flush) begin
            // Result and destination are meaningless behind a bubble; hold them.
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
        end else if (!stall) begin
            r_valid <= in_valid;
            r_res   <= res;
            r_dst   <= dst;
            r_wr_en <= wr_en & in_valid;
        end
    end

    // Architectural flags: updated only by committing ALU instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zr  <= 1'b0;
            r_neg <= 1'b0;
            r_ov  <= 1'b0;
        end else if (w_commit) begin
            if (w_upd_znv) begin
                r_zr  <= w_res_zero;
                r_neg <= w_sign_r;
                r_ov  <= w_ov_new;
            end else if (w_upd_z) begin
                r_zr  <= w_res_zero;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_res   = r_res;
    assign out_dst   = r_dst;
    assign out_wr_en = r_wr_en;
    assign zr        = r_zr;
    assign neg       = r_neg;
    assign ov        = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_ex_result_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_result_flags
// Description : Self-checking bench for ex_result_flags with directed
//               scenarios and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_result_flags;

    localparam int DW = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [3:0]    opcode;
    logic [DW-1:0] in1, in2, res;
    logic [RW-1:0] dst;
    logic          wr_en, stall, flush;
    logic          out_valid;
    logic [DW-1:0] out_res;
    logic [RW-1:0] out_dst;
    logic          out_wr_en;
    logic          zr, neg, ov;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic          m_valid, m_wr, m_zr, m_neg, m_ov;
    logic [DW-1:0] m_res;
    logic [RW-1:0] m_dst;

    ex_result_flags #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .in1(in1), .in2(in2), .res(res), .dst(dst), .wr_en(wr_en),
        .stall(stall), .flush(flush), .out_valid(out_valid),
        .out_res(out_res), .out_dst(out_dst), .out_wr_en(out_wr_en),
        .zr(zr), .neg(neg), .ov(ov)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] dut_state();
        return {out_valid, out_res, out_dst, out_wr_en, zr, neg, ov};
    endfunction

    function automatic logic [24:0] model_state();
        return {m_valid, m_res, m_dst, m_wr, m_zr, m_neg, m_ov};
    endfunction

    task automatic model_clear();
        m_valid = 0; m_res = '0; m_dst = '0; m_wr = 0;
        m_zr = 0; m_neg = 0; m_ov = 0;
    endtask

    // Behavioural model: signed interpretation of operands and result.
    task automatic model_step();
        bit a_neg, b_neg, r_neg, commit;
        a_neg  = $signed(in1) < 0;
        b_neg  = $signed(in2) < 0;
        r_neg  = $signed(res) < 0;
        commit = in_valid && !stall && !flush;
        if (commit) begin
            if (opcode == 4'd0 || opcode == 4'd2) begin
                m_zr  = (res == 0);
                m_neg = r_neg;
                if (opcode == 4'd0) m_ov = (a_neg == b_neg) && (r_neg != a_neg);
                else                m_ov = (a_neg != b_neg) && (r_neg != a_neg);
            end else if (opcode <= 4'd7) begin
                m_zr = (res == 0);
            end
        end
        if (flush) begin
            m_valid = 0; m_wr = 0;
        end else if (!stall) begin
            m_valid = in_valid; m_res = res; m_dst = dst; m_wr = wr_en && in_valid;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] r, input logic [3:0] d,
                         input logic w, input logic s, input logic f);
        in_valid = v; opcode = op; in1 = a; in2 = b; res = r; dst = d;
        wr_en = w; stall = s; flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (dut_state() !== 25'd0) begin
            fails++;
            $display("FAIL reset_state got=%h want=%h", dut_state(), 25'd0);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_sub_overflow();
        drive(1, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'd1, 1, 0, 0);
        tick();
        tests++;
        if ({ov, neg, zr, out_res} !== {1'b1, 1'b1, 1'b0, 16'h8000}) begin
            fails++;
            $display("FAIL add_ovf got ov=%b neg=%b zr=%b res=%h want ov=1 neg=1 zr=0 res=8000",
                     ov, neg, zr, out_res);
        end
        drive(1, 4'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'd2, 1, 0, 0);
        tick();
        tests++;
        if ({ov, neg, zr} !== 3'b100) begin
            fails++;
            $display("FAIL sub_ovf got ov=%b neg=%b zr=%b want ov=1 neg=0 zr=0", ov, neg, zr);
        end
        tests++;
        if (dut_state() !== model_state()) begin
            fails++;
            $display("FAIL sub_model got=%h want=%h", dut_state(), model_state());
        end
    endtask

    task automatic test_zr_only();
        drive(1, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'd1, 1, 0, 0);
        tick();
        drive(1, 4'd1, 16'h8080, 16'h8080, 16'h0000, 4'd2, 1, 0, 0);
        tick();
        tests++;
        if ({zr, neg, ov} !== 3'b111) begin
            fails++;
            $display("FAIL paddsb_zr got zr=%b neg=%b ov=%b want 1 1 1", zr, neg, ov);
        end
        drive(1, 4'd3, 16'hFFFF, 16'h00F0, 16'h00F0, 4'd3, 1, 0, 0);
        tick();
        tests++;
        if ({zr, neg, ov} !== 3'b011) begin
            fails++;
            $display("FAIL and_zr got zr=%b neg=%b ov=%b want 0 1 1", zr, neg, ov);
        end
        drive(1, 4'd8, 16'h0000, 16'h0000, 16'h0000, 4'd4, 1, 0, 0);
        tick();
        tests++;
        if ({zr, neg, ov, out_valid, out_res} !== {3'b011, 1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL nonalu_flags got zr=%b neg=%b ov=%b v=%b res=%h want 0 1 1 1 0000",
                     zr, neg, ov, out_valid, out_res);
        end
    endtask

    task automatic test_stall();
        logic [24:0] snap;
        snap = dut_state();
        drive(1, 4'd0, 16'h0001, 16'hFFFF, 16'h0000, 4'd7, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (dut_state() !== snap) begin
                fails++;
                $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, dut_state(), snap);
            end
        end
        stall = 1'b0;
        tick();
        tests++;
        if ({zr, out_valid, out_dst} !== {1'b1, 1'b1, 4'd7}) begin
            fails++;
            $display("FAIL stall_release got zr=%b v=%b dst=%0d want 1 1 7", zr, out_valid, out_dst);
        end
        drive(0, 4'd3, 16'h0, 16'h0, 16'h0F0F, 4'd0, 1, 0, 0);
        tick();
        tests++;
        if ({out_valid, out_wr_en, zr} !== 3'b001) begin
            fails++;
            $display("FAIL stall_once got v=%b we=%b zr=%b want 0 0 1", out_valid, out_wr_en, zr);
        end
    endtask

    task automatic test_flush();
        drive(1, 4'd0, 16'h1000, 16'h0234, 16'h1234, 4'd6, 1, 0, 0);
        tick();
        drive(1, 4'd2, 16'h1234, 16'h1234, 16'h0000, 4'd8, 1, 1, 1);
        tick();
        tests++;
        if ({out_valid, out_wr_en, zr} !== 3'b000) begin
            fails++;
            $display("FAIL flush_stall got v=%b we=%b zr=%b want 0 0 0", out_valid, out_wr_en, zr);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3] = '{4'd0, 4'd3, 4'd7};
        logic [3:0] dsts[3] = '{4'd3, 4'd5, 4'd9};
        for (int i = 0; i < 3; i++) begin
            drive(1, ops[i], 16'h0011, 16'h0022, 16'h0033, dsts[i], 1, 0, 0);
            tick();
            tests++;
            if ({out_dst, out_wr_en, out_valid} !== {dsts[i], 1'b1, 1'b1}) begin
                fails++;
                $display("FAIL b2b_%0d got dst=%0d we=%b v=%b want dst=%0d we=1 v=1",
                         i, out_dst, out_wr_en, out_valid, dsts[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r;
        logic [3:0]  op;
        for (int i = 0; i < 400; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: r = 16'h0000;
                1: r = (op == 4'd2) ? a - b : a + b;
                default: r = 16'($urandom);
            endcase
            drive($urandom_range(0, 9) < 8, op, a, b, r, 4'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            tick();
            tests++;
            if (dut_state() !== model_state()) begin
                fails++;
                $display("FAIL random_%0d got=%h want=%h", i, dut_state(), model_state());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'd5, 1, 0, 0);
        tick();
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL async_pre got v=%b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        tests++;
        if (dut_state() !== 25'd0) begin
            fails++;
            $display("FAIL async_reset got=%h want=%h", dut_state(), 25'd0);
        end
        rst = 1'b0;
        drive(0, 4'd0, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);
        tick();
        tests++;
        if (dut_state() !== model_state()) begin
            fails++;
            $display("FAIL after_reset got=%h want=%h", dut_state(), model_state());
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_add_sub_overflow();
        test_zr_only();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_result_flags.md
Name: ex_result_flags

Overview:
- Registered execute-stage back end of the 16-bit datapath. Sits directly downstream of the packed saturating byte adder and the other ALU functions.
- Captures the ALU result, destination register and write-enable into the EX/MEM pipeline register.
- Computes and holds the architectural Z/N/V condition flags, using per-opcode update rules.
- Honours pipeline stall and flush so that flags change only for instructions that actually commit from EX.

Parameters:
- DW, 16, datapath width; in1, in2 and res are DW bits.
- RW, 4, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a real instruction is present in EX this cycle.
- opcode  input  4  EX instruction opcode.
- in1  input  DW  ALU operand A; only bit DW-1 is used.
- in2  input  DW  ALU operand B; only bit DW-1 is used.
- res  input  DW  ALU result, e.g. the packed-saturating sum.
- dst  input  RW  destination register index.
- wr_en  input  1  instruction writes the register file.
- stall  input  1  hold the EX/MEM register this cycle.
- flush  input  1  squash the EX instruction and insert a bubble.
- out_valid  output  1  EX/MEM stage holds a real instruction.
- out_res  output  DW  registered result.
- out_dst  output  RW  registered destination.
- out_wr_en  output  1  registered write-enable, gated by out_valid.
- zr  output  1  zero flag.
- neg  output  1  negative flag.
- ov  output  1  overflow flag.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_res=0, out_dst=0, out_wr_en=0, zr=0, neg=0, ov=0. Reset takes effect immediately, mid-operation included, and overrides stall and flush.
- Opcode map:
  - 0000 ADD, 0001 PADDSB, 0010 SUB, 0011 AND, 0100 NOR, 0101 SLL, 0110 SRL, 0111 SRA.
  - All other opcodes are non-ALU.
- Commit condition: commit = in_valid & ~stall & ~flush.
- Pipeline register update, evaluated each rising edge:
  - flush=1: out_valid<=0 and out_wr_en<=0. Flush takes priority over stall. out_res and out_dst are don't-care and are held.
  - else stall=1: every output register holds its value, flags included.
  - else: out_valid<=in_valid, out_res<=res, out_dst<=dst, out_wr_en<=wr_en & in_valid.
- Flag update happens only on commit; otherwise all three flags hold.
- Flag rules:
  - ADD and SUB update zr, neg and ov.
  - PADDSB, AND, NOR, SLL, SRL and SRA update zr only; neg and ov hold.
  - Non-ALU opcodes update no flag.
- Flag formulas:
  - zr = (res == 0).
  - neg = res[DW-1].
  - ADD ov = (in1[DW-1] == in2[DW-1]) & (res[DW-1] != in1[DW-1]).
  - SUB (in1-in2) ov = (in1[DW-1] != in2[DW-1]) & (res[DW-1] != in1[DW-1]).
- PADDSB never sets ov, because its per-byte saturation is handled upstream. Its zr is computed on the full 16-bit packed result.
- Latency: 1 cycle from EX inputs to the registered outputs and flags. There is no combinational path from inputs to outputs.
- Bubble: in_valid=0 with no stall or flush loads out_valid=0 and out_wr_en=0, and flags hold.
- stall and flush both asserted behaves as flush.
- A stall lasting any number of cycles followed by release commits the instruction presented on the release cycle exactly once.

Test Plan:
- Reset → all outputs 0. Assert rst mid-stream while out_valid=1 → outputs clear before the next edge.
- ADD with in1=7FFF, in2=0001, res=8000, commit → ov=1, neg=1, zr=0, out_res=8000 one cycle later. Then SUB with in1=8000, in2=0001, res=7FFF → ov=1, neg=0.
- ADD setting neg=1 and ov=1, then PADDSB with res=0000 → zr=1, while neg=1 and ov=1 are held. Then opcode 1000 with res=0000 → no flag changes.
- ADD with res=0000 presented with stall=1 for 3 cycles, then released → flags and outputs held through the stall; zr=1 and out_valid=1 exactly once after release.
- flush=1 together with stall=1 on a SUB with res=0000 → out_valid=0, out_wr_en=0, and zr unchanged.
- Back-to-back committed ops ADD, AND, SRA with wr_en=1 and dst=3,5,9 → out_dst sequence 3,5,9 with out_wr_en=1 each cycle.
